// File: rtl/qu_decode_pkg.sv
// -----------------------------------------------------------------------------
// qu_decode_pkg
// Shared RV32I decode definitions for the Qu processor: instruction/PC/immediate
// types, 3-bit optype codes, base opcodes, the decoded-instruction bundle and
// the immediate extraction function used by the decode stage.
// No ports (package).
// -----------------------------------------------------------------------------
package qu_decode_pkg;

    localparam int QU_PC_WIDTH    = 12;
    localparam int QU_INSTR_WIDTH = 32;

    typedef logic [QU_INSTR_WIDTH-1:0] instr_t;
    typedef logic [QU_PC_WIDTH-1:0]    pc_t;
    typedef logic [31:0]               imm32_t;

    // Operation classes handed to dispatch
    localparam logic [2:0] OPTYPE_ALU     = 3'd0;
    localparam logic [2:0] OPTYPE_LOAD    = 3'd1;
    localparam logic [2:0] OPTYPE_STORE   = 3'd2;
    localparam logic [2:0] OPTYPE_BRANCH  = 3'd3;
    localparam logic [2:0] OPTYPE_JUMP    = 3'd4;
    localparam logic [2:0] OPTYPE_UPPER   = 3'd5;
    localparam logic [2:0] OPTYPE_SYSTEM  = 3'd6;
    localparam logic [2:0] OPTYPE_ILLEGAL = 3'd7;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef struct packed {
        pc_t         pc;
        logic [2:0]  optype;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_valid;
        logic        rs1_valid;
        logic        rs2_valid;
        imm32_t      imm;
        logic        imm_valid;
        logic        illegal;
    } dec_instr_t;

    // Sign-extended immediate selected by the instruction format implied by the
    // opcode. R-type and unknown opcodes yield zero.
    function automatic imm32_t decode_imm(input instr_t instr);
        imm32_t imm;
        imm = 32'd0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/qu_decode_comb.sv
// -----------------------------------------------------------------------------
// qu_decode_comb
// Purely combinational RV32I decoder: raw instruction + PC -> dec_instr_t,
// including illegal-instruction detection. Illegal encodings are reported as
// optype ILLEGAL with every valid bit cleared so nothing downstream reads or
// writes registers for them.
// Ports:
//   instr_i  raw 32-bit instruction
//   pc_i     instruction PC (carried through)
//   dec_o    decoded bundle
// -----------------------------------------------------------------------------
module qu_decode_comb
    import qu_decode_pkg::*;
(
    input  instr_t     instr_i,
    input  pc_t        pc_i,
    output dec_instr_t dec_o
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic [2:0] optype_s;
    logic       rd_use_s;
    logic       rs1_use_s;
    logic       rs2_use_s;
    logic       imm_use_s;
    logic       bad_s;

    assign opcode_s = instr_i[6:0];
    assign funct3_s = instr_i[14:12];
    assign funct7_s = instr_i[31:25];

    // Classify the opcode, mark which operands the format carries, flag bad encodings
    always_comb begin
        optype_s  = OPTYPE_ALU;
        rd_use_s  = 1'b0;
        rs1_use_s = 1'b0;
        rs2_use_s = 1'b0;
        imm_use_s = 1'b1;
        bad_s     = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                optype_s  = OPTYPE_ALU;
                rd_use_s  = 1'b1;
                rs1_use_s = 1'b1;
                rs2_use_s = 1'b1;
                imm_use_s = 1'b0;
                // funct7 0x20 only exists for SUB and SRA
                if (funct7_s == 7'h00) begin
                    bad_s = 1'b0;
                end else if (funct7_s == 7'h20) begin
                    bad_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                end else begin
                    bad_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                optype_s  = OPTYPE_ALU;
                rd_use_s  = 1'b1;
                rs1_use_s = 1'b1;
                // Shift-immediates reuse funct7 as an encoding field
                if (funct3_s == 3'b001) begin
                    bad_s = (funct7_s != 7'h00);
                end else if (funct3_s == 3'b101) begin
                    bad_s = !((funct7_s == 7'h00) || (funct7_s == 7'h20));
                end else begin
                    bad_s = 1'b0;
                end
            end
            OPC_LOAD: begin
                optype_s  = OPTYPE_LOAD;
                rd_use_s  = 1'b1;
                rs1_use_s = 1'b1;
                bad_s     = (funct3_s == 3'b011) || (funct3_s == 3'b110) ||
                            (funct3_s == 3'b111);
            end
            OPC_STORE: begin
                optype_s  = OPTYPE_STORE;
                rs1_use_s = 1'b1;
                rs2_use_s = 1'b1;
                bad_s     = (funct3_s > 3'b010);
            end
            OPC_BRANCH: begin
                optype_s  = OPTYPE_BRANCH;
                rs1_use_s = 1'b1;
                rs2_use_s = 1'b1;
                bad_s     = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            end
            OPC_JAL: begin
                optype_s = OPTYPE_JUMP;
                rd_use_s = 1'b1;
            end
            OPC_JALR: begin
                optype_s  = OPTYPE_JUMP;
                rd_use_s  = 1'b1;
                rs1_use_s = 1'b1;
                bad_s     = (funct3_s != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                optype_s = OPTYPE_UPPER;
                rd_use_s = 1'b1;
            end
            OPC_SYSTEM, OPC_MISC_MEM: begin
                optype_s  = OPTYPE_SYSTEM;
                rd_use_s  = 1'b1;
                rs1_use_s = 1'b1;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
        // Compressed / non-32-bit encodings are not supported
        if (instr_i[1:0] != 2'b11) begin
            bad_s = 1'b1;
        end else begin
            bad_s = bad_s;
        end
    end

    // Assemble the bundle; illegal instructions suppress all operand/immediate use
    always_comb begin
        dec_o.pc        = pc_i;
        dec_o.funct3    = funct3_s;
        dec_o.funct7_b5 = instr_i[30];
        dec_o.rd        = instr_i[11:7];
        dec_o.rs1       = instr_i[19:15];
        dec_o.rs2       = instr_i[24:20];
        if (bad_s) begin
            dec_o.optype    = OPTYPE_ILLEGAL;
            dec_o.illegal   = 1'b1;
            dec_o.rd_valid  = 1'b0;
            dec_o.rs1_valid = 1'b0;
            dec_o.rs2_valid = 1'b0;
            dec_o.imm       = 32'd0;
            dec_o.imm_valid = 1'b0;
        end else begin
            dec_o.optype    = optype_s;
            dec_o.illegal   = 1'b0;
            // x0 as destination is a no-write
            dec_o.rd_valid  = rd_use_s && (instr_i[11:7] != 5'd0);
            dec_o.rs1_valid = rs1_use_s;
            dec_o.rs2_valid = rs2_use_s;
            dec_o.imm       = imm_use_s ? decode_imm(instr_i) : 32'd0;
            dec_o.imm_valid = imm_use_s;
        end
    end

endmodule

// File: rtl/qu_decode.sv
// -----------------------------------------------------------------------------
// qu_decode
// Decode stage of the Qu processor. Accepts fetched instructions over a
// valid/ready handshake, decodes them combinationally at accept time and holds
// the result in a registered output slot backed by one skid slot, so full
// throughput is kept while absorbing one cycle of dispatch backpressure.
// Optional build macro: QU_DECODE_PERF_CNT_EN adds perf_decoded / perf_stall.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous kill of both held entries and any input
//   in_valid/in_ready       fetch handshake (in_ready registered, = !skid full)
//   in_instr, in_pc         fetched instruction and its PC
//   out_valid/out_ready     dispatch handshake
//   out_dec                 registered decoded bundle
//   perf_decoded            (macro) output transfers, wraps at 2^32
//   perf_stall              (macro) cycles with in_valid && !in_ready
// Only the default widths (PC 12, instruction 32) are supported.
// -----------------------------------------------------------------------------
module qu_decode
    import qu_decode_pkg::*;
#(
    parameter int PC_WIDTH    = QU_PC_WIDTH,
    parameter int INSTR_WIDTH = QU_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output dec_instr_t             out_dec
`ifdef QU_DECODE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_decoded,
    output logic [31:0]            perf_stall
`endif
);

    dec_instr_t dec_s;
    dec_instr_t out_q, out_d;
    dec_instr_t skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_full_q, skid_full_d;
    logic       in_ready_q, in_ready_d;
    logic       accept_s;
    logic       drain_s;

    qu_decode_comb u_comb (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .dec_o   (dec_s)
    );

    assign accept_s = in_valid && in_ready_q;
    assign drain_s  = out_valid_q && out_ready;

    // Next-state of the output/skid pair; flush wins over accept and drain
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (!out_valid_q || drain_s) begin
            // Output slot frees up this cycle: oldest held entry moves in first
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                if (accept_s) begin
                    skid_d      = dec_s;
                    skid_full_d = 1'b1;
                end else begin
                    skid_full_d = 1'b0;
                end
            end else if (accept_s) begin
                out_d       = dec_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output is stalled; a new entry parks in the skid slot
            if (accept_s) begin
                skid_d      = dec_s;
                skid_full_d = 1'b1;
            end else begin
                skid_full_d = skid_full_q;
            end
        end
        in_ready_d = !skid_full_d;
    end

    // Handshake and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_dec   = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef QU_DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded_q;
    logic [31:0] perf_stall_q;

    // Performance counters; deliberately not cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            if (drain_s) begin
                perf_decoded_q <= perf_decoded_q + 32'd1;
            end
            if (in_valid && !in_ready_q) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_qu_decode.sv
// -----------------------------------------------------------------------------
// tb_qu_decode
// Self-checking bench for qu_decode. A hand-written table holds each test
// instruction with its expected decode; accepted instructions push their
// expected bundle to a scoreboard queue and every output transfer pops and
// compares it.
// -----------------------------------------------------------------------------
module tb_qu_decode;
    import qu_decode_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  opt;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdv;
        logic        rs1v;
        logic        rs2v;
        logic [31:0] imm;
        logic        immv;
        logic        ill;
        logic [11:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [11:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    dec_instr_t  out_dec;
`ifdef QU_DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_stall;
`endif

    logic        rand_rdy;
    logic        rnd_rdy;
    logic        rdy_man;
    assign out_ready = rand_rdy ? rnd_rdy : rdy_man;

    int          n_checks;
    int          n_errors;
    int          n_out;
    int          n_stall;
    int          pc_cnt;
    exp_t        vtab[$];
    exp_t        sb[$];
    exp_t        cur_exp;

    qu_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec)
`ifdef QU_DECODE_PERF_CNT_EN
        ,
        .perf_decoded (perf_decoded),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random downstream readiness, used only when rand_rdy is set
    initial rnd_rdy = 1'b1;
    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic addv(input logic [31:0] instr, input logic [2:0] opt, input logic f7b5,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic rdv, input logic rs1v, input logic rs2v,
                        input logic [31:0] imm, input logic immv, input logic ill);
        exp_t e;
        e.instr = instr; e.opt = opt; e.f7b5 = f7b5;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.rdv = rdv; e.rs1v = rs1v; e.rs2v = rs2v;
        e.imm = imm; e.immv = immv; e.ill = ill; e.pc = 12'd0;
        vtab.push_back(e);
    endtask

    task automatic compare_out(input exp_t e);
        check_eq("pc", out_dec.pc, e.pc);
        check_eq("optype", out_dec.optype, e.opt);
        check_eq("illegal", out_dec.illegal, e.ill);
        check_eq("rd_valid", out_dec.rd_valid, e.rdv);
        check_eq("rs1_valid", out_dec.rs1_valid, e.rs1v);
        check_eq("rs2_valid", out_dec.rs2_valid, e.rs2v);
        check_eq("imm_valid", out_dec.imm_valid, e.immv);
        check_eq("funct3", out_dec.funct3, e.instr[14:12]);
        if (!e.ill) begin
            check_eq("funct7_b5", out_dec.funct7_b5, e.f7b5);
            check_eq("imm", out_dec.imm, e.imm);
        end
        if (e.rdv)  check_eq("rd", out_dec.rd, e.rd);
        if (e.rs1v) check_eq("rs1", out_dec.rs1, e.rs1);
        if (e.rs2v) check_eq("rs2", out_dec.rs2, e.rs2);
    endtask

    // Scoreboard monitor, sampling on the inactive edge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            n_out   = 0;
            n_stall = 0;
        end else begin
            if (in_valid && !in_ready) n_stall++;
            if (out_valid && out_ready) n_out++;
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check_eq("unexpected_out", 64'd1, 64'd0);
                    else compare_out(sb.pop_front());
                end
                if (in_valid && in_ready) sb.push_back(cur_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        exp_t e;
        e = vtab[idx];
        e.pc = 12'(pc_cnt);
        pc_cnt += 4;
        cur_exp  = e;
        in_instr = e.instr;
        in_pc    = e.pc;
        in_valid = 1'b1;
    endtask

    task automatic send(input int idx);
        bit acc;
        drive(idx);
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 200 && (sb.size() != 0 || out_valid); k++) tick();
        check_eq("drained", sb.size(), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 12'd0;
        rand_rdy = 1'b0; rdy_man = 1'b1;
        n_checks = 0; n_errors = 0; pc_cnt = 0;
        //     instr         opt   f7  rd     rs1    rs2    rdv   rs1v  rs2v  imm           immv  ill
        addv(32'hFFF10093, 3'd0, 1'b1, 5'd1,  5'd2,  5'd31, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        addv(32'hFE208EE3, 3'd3, 1'b1, 5'd29, 5'd1,  5'd2,  1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
        addv(32'h123452B7, 3'd5, 1'b0, 5'd5,  5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 32'h12345000, 1'b1, 1'b0);
        addv(32'h00000000, 3'd7, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'h002081B3, 3'd0, 1'b0, 5'd3,  5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0);
        addv(32'h402081B3, 3'd0, 1'b1, 5'd3,  5'd1,  5'd2,  1'b1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0);
        addv(32'h402091B3, 3'd7, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'h022081B3, 3'd7, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'h40315093, 3'd0, 1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b0, 32'h00000403, 1'b1, 1'b0);
        addv(32'h40311093, 3'd7, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'h00812283, 3'd1, 1'b0, 5'd5,  5'd2,  5'd8,  1'b1, 1'b1, 1'b0, 32'h00000008, 1'b1, 1'b0);
        addv(32'h00813283, 3'd7, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'hFE512E23, 3'd2, 1'b1, 5'd28, 5'd2,  5'd5,  1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
        addv(32'hFE513E23, 3'd7, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'h008000EF, 3'd4, 1'b0, 5'd1,  5'd0,  5'd8,  1'b1, 1'b0, 1'b0, 32'h00000008, 1'b1, 1'b0);
        addv(32'h00008067, 3'd4, 1'b0, 5'd0,  5'd1,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);
        addv(32'h00009067, 3'd7, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'hFE20AEE3, 3'd7, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'h00000012, 3'd7, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
        addv(32'hFFFFF517, 3'd5, 1'b1, 5'd10, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 32'hFFFFF000, 1'b1, 1'b0);
        addv(32'h00000013, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0);

        // Reset state
        #12;
        check_eq("rst_out_valid", out_valid, 64'd0);
        check_eq("rst_in_ready", in_ready, 64'd1);
        check_eq("rst_out_dec", out_dec, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Full-throughput pass; first accept must show up one cycle later
        send(0);
        check_eq("latency_1", out_valid, 64'd1);
        for (int i = 1; i < vtab.size(); i++) send(i);
        drain();

        // Backpressure: only two entries fit while dispatch is stalled
        rdy_man = 1'b0;
        drive(4); tick();
        drive(5); tick();
        drive(8);
        check_eq("bp_in_ready", in_ready, 64'd0);
        tick();
        check_eq("bp_accepted", sb.size(), 64'd2);
        in_valid = 1'b0;
        rdy_man  = 1'b1;
        tick();
        check_eq("bp_consecutive", out_valid, 64'd1);
        tick();
        check_eq("bp_empty", out_valid, 64'd0);
        check_eq("bp_sb_empty", sb.size(), 64'd0);

        // Flush with both slots full and input offered
        rdy_man = 1'b0;
        drive(0); tick();
        drive(1); tick();
        drive(2); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_out_valid", out_valid, 64'd0);
        check_eq("flush_in_ready", in_ready, 64'd1);
        // Flush while in_ready is high: the same-cycle input must be dropped
        drive(10); tick();
        drive(12); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush2_out_valid", out_valid, 64'd0);
        check_eq("flush2_in_ready", in_ready, 64'd1);
        rdy_man = 1'b1;
        repeat (3) tick();
        check_eq("flush_gone", out_valid, 64'd0);

        // Random dispatch stalls exercise the skid path in every combination
        rand_rdy = 1'b1;
        for (int i = 0; i < vtab.size(); i++) send(i);
        for (int i = vtab.size() - 1; i >= 0; i--) send(i);
        drain();
        rand_rdy = 1'b0;
        tick();
`ifdef QU_DECODE_PERF_CNT_EN
        check_eq("perf_decoded", perf_decoded, 64'(n_out));
        check_eq("perf_stall", perf_stall, 64'(n_stall));
`endif

        // Asynchronous reset between edges with both slots full
        rdy_man = 1'b0;
        drive(2); tick();
        drive(14); tick();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 64'd0);
        check_eq("arst_in_ready", in_ready, 64'd1);
        check_eq("arst_out_dec", out_dec, 64'd0);
`ifdef QU_DECODE_PERF_CNT_EN
        check_eq("arst_perf_decoded", perf_decoded, 64'd0);
        check_eq("arst_perf_stall", perf_stall, 64'd0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        rdy_man = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(i);
        drain();
        check_eq("final_out_valid", out_valid, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
